filter_bank_mc: RTL

- Multi-channel successor to filter_bank: CHANNELS independent audio channels, each through a cascade of FILTER_COUNT one-pole stages.
- Each stage is individually low-pass, high-pass or bypass.
- All stages are time-multiplexed onto one multiplier.
- Sits between the audio source (valid-strobed samples) and the mixer/DAC; configured over the 8-bit Wishbone register bus.

---
 rtl/filter_bank_pkg.sv | 38 +++
 rtl/filter_stage_mac.sv | 61 ++++++
 rtl/filter_bank_mc.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/filter_bank_pkg.sv
// rtl/filter_bank_pkg.sv - register offsets, encodings, FSM states and helpers for filter_bank_mc
package filter_bank_pkg;

  localparam logic [7:0] CTRL_OFF   = 8'd0;
  localparam logic [7:0] STATUS_OFF = 8'd1;
  localparam logic [7:0] COEF_BASE  = 8'd2;

  // Mode registers follow the two coefficient bytes of every stage.
  function automatic logic [7:0] mode_base(input int filters);
    return 8'(int'(COEF_BASE) + 2 * filters);
  endfunction

  typedef enum logic [1:0] {
    MODE_BYP = 2'd0,
    MODE_LP  = 2'd1,
    MODE_HP  = 2'd2,
    MODE_RSV = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_ACC,
    S_DONE
  } fsm_e;

  function automatic logic signed [31:0] saturate(input logic signed [31:0] v, input int bits);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (bits - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (bits - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/filter_stage_mac.sv
// rtl/filter_stage_mac.sv - one-pole stage datapath: diff, multiply, accumulate, round, saturate
module filter_stage_mac
  import filter_bank_pkg::*;
#(
  parameter int B      = 8,
  parameter int COEF_W = 16,
  parameter int GUARD  = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      mul_en,
  input  logic [1:0]                mode,
  input  logic signed [B-1:0]       x,
  input  logic signed [B+GUARD-1:0] y,
  input  logic [COEF_W-1:0]         k,
  output logic signed [B+GUARD-1:0] y_next,
  output logic signed [B-1:0]       out
);

  localparam int SW = B + GUARD;
  localparam int DW = SW + 1;
  localparam int PW = DW + COEF_W + 1;

  logic signed [SW-1:0] xs;
  logic signed [SW-1:0] y_new;
  logic signed [SW-1:0] step;
  logic signed [DW-1:0] diff;
  logic signed [PW-1:0] diff_x;
  logic signed [PW-1:0] k_x;
  logic signed [PW-1:0] prod_q;
  logic signed [31:0]   lp_s;
  logic signed [31:0]   hp_s;
  logic                 filt;

  assign xs     = {x, {GUARD{1'b0}}};
  assign diff   = {xs[SW-1], xs} - {y[SW-1], y};
  assign diff_x = PW'(diff);
  assign k_x    = PW'({1'b0, k});

  always_ff @(posedge clk) begin
    if (!rstn) prod_q <= '0;
    else if (mul_en) prod_q <= diff_x * k_x;
  end

  // y moves toward x by a fraction of the gap, so the sum never leaves SW bits.
  assign step  = SW'(prod_q >>> COEF_W);
  assign y_new = y + step;

  assign lp_s = saturate((32'(y_new) + (32'sd1 <<< (GUARD - 1))) >>> GUARD, B);
  assign hp_s = saturate((32'(xs) - 32'(y_new) + (32'sd1 <<< (GUARD - 1))) >>> GUARD, B);

  assign filt   = (mode == MODE_LP) || (mode == MODE_HP);
  assign y_next = filt ? y_new : y;

  always_comb begin
    out = x;
    if (mode == MODE_LP) out = B'(lp_s);
    else if (mode == MODE_HP) out = B'(hp_s);
  end

endmodule

// File: rtl/filter_bank_mc.sv
// rtl/filter_bank_mc.sv - multi-channel cascaded one-pole filter bank sharing one multiplier
module filter_bank_mc
  import filter_bank_pkg::*;
#(
  parameter int          AUDIO_BDEPTH = 8,
  parameter int          CHANNELS     = 2,
  parameter int          FILTER_COUNT = 4,
  parameter int          COEF_W       = 16,
  parameter int          GUARD        = 8,
  parameter logic [15:0] BASE_ADDRESS = 16'h0000
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [15:0]                      adr_i,
  input  logic [7:0]                       dat_i,
  output logic [7:0]                       dat_o,
  input  logic                             we_i,
  input  logic                             sel_i,
  input  logic                             stb_i,
  input  logic                             cyc_i,
  output logic                             ack_o,
  input  logic [2:0]                       cti_i,
  input  logic [CHANNELS*AUDIO_BDEPTH-1:0] audio_in,
  input  logic                             valid_in,
  output logic [CHANNELS*AUDIO_BDEPTH-1:0] audio_out,
  output logic                             valid_out
);

  localparam int B  = AUDIO_BDEPTH;
  localparam int SW = B + GUARD;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int FW = (FILTER_COUNT > 1) ? $clog2(FILTER_COUNT) : 1;
  localparam int NS = CHANNELS * FILTER_COUNT;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [7:0] MODE_OFF = mode_base(FILTER_COUNT);

  logic [15:0] offs;
  logic [7:0]  off8;
  logic        access, take, wr, clear_wr, sts_clr;
  logic [7:0]  rd_data;
  logic        unused_cti;

  logic        ctrl_en;
  logic [15:0] coef [FILTER_COUNT];
  logic [1:0]  mode [FILTER_COUNT];
  logic [15:0] coef_act [FILTER_COUNT];
  logic [1:0]  mode_act [FILTER_COUNT];
  logic        en_act;

  fsm_e                 fsm;
  logic [CW-1:0]        ch;
  logic [FW-1:0]        stg;
  logic [IW-1:0]        cur_idx;
  logic signed [B-1:0]  samp [CHANNELS];
  logic signed [B-1:0]  res  [CHANNELS];
  logic signed [SW-1:0] st_mem [NS];
  logic signed [B-1:0]  x_cur;
  logic signed [SW-1:0] y_cur;
  logic signed [SW-1:0] y_next;
  logic signed [B-1:0]  stage_out;
  logic [1:0]           mac_mode;
  logic                 overrun, clear_pend;

  assign unused_cti = ^cti_i;
  assign offs     = adr_i - BASE_ADDRESS;
  assign off8     = offs[7:0];
  assign access   = cyc_i & stb_i & (offs[15:8] == 8'h00);
  assign take     = access & ~ack_o;
  assign wr       = take & we_i & sel_i;
  assign clear_wr = wr & (off8 == CTRL_OFF) & dat_i[1];
  assign sts_clr  = wr & (off8 == STATUS_OFF) & dat_i[1];
  assign cur_idx  = IW'(int'(ch) * FILTER_COUNT + int'(stg));
  assign mac_mode = en_act ? mode_act[stg] : MODE_BYP;

  always_comb begin
    rd_data = 8'h00;
    if (off8 == CTRL_OFF) rd_data = {7'b0, ctrl_en};
    else if (off8 == STATUS_OFF) rd_data = {6'b0, overrun, fsm != S_IDLE};
    for (int i = 0; i < FILTER_COUNT; i++) begin
      if (off8 == 8'(int'(COEF_BASE) + 2 * i)) rd_data = coef[i][7:0];
      if (off8 == 8'(int'(COEF_BASE) + 2 * i + 1)) rd_data = coef[i][15:8];
      if (off8 == MODE_OFF + 8'(i)) rd_data = {6'b0, mode[i]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ack_o   <= 1'b0;
      dat_o   <= 8'h00;
      ctrl_en <= 1'b0;
      for (int i = 0; i < FILTER_COUNT; i++) begin
        coef[i] <= '0;
        mode[i] <= '0;
      end
    end else begin
      ack_o <= take;
      dat_o <= take ? rd_data : 8'h00;
      if (wr) begin
        if (off8 == CTRL_OFF) ctrl_en <= dat_i[0];
        for (int i = 0; i < FILTER_COUNT; i++) begin
          if (off8 == 8'(int'(COEF_BASE) + 2 * i)) coef[i][7:0] <= dat_i;
          if (off8 == 8'(int'(COEF_BASE) + 2 * i + 1)) coef[i][15:8] <= dat_i;
          if (off8 == MODE_OFF + 8'(i)) mode[i] <= dat_i[1:0];
        end
      end
    end
  end

  // Config is snapshotted when a sample is accepted so bus writes only affect later samples.
  always_ff @(posedge clk_i) begin
    valid_out <= 1'b0;
    if (!rst_i) begin
      fsm        <= S_IDLE;
      ch         <= '0;
      stg        <= '0;
      x_cur      <= '0;
      y_cur      <= '0;
      en_act     <= 1'b0;
      overrun    <= 1'b0;
      clear_pend <= 1'b0;
      audio_out  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        samp[i] <= '0;
        res[i]  <= '0;
      end
      for (int i = 0; i < FILTER_COUNT; i++) begin
        coef_act[i] <= '0;
        mode_act[i] <= '0;
      end
      for (int i = 0; i < NS; i++) st_mem[i] <= '0;
    end else begin
      if (sts_clr) overrun <= 1'b0;
      if (valid_in && fsm != S_IDLE) overrun <= 1'b1;
      if (clear_wr && fsm != S_IDLE) clear_pend <= 1'b1;
      case (fsm)
        S_IDLE: begin
          if (clear_wr || clear_pend) begin
            for (int i = 0; i < NS; i++) st_mem[i] <= '0;
            clear_pend <= 1'b0;
          end
          if (valid_in) begin
            for (int i = 0; i < CHANNELS; i++) samp[i] <= audio_in[i*B +: B];
            for (int i = 0; i < FILTER_COUNT; i++) begin
              coef_act[i] <= coef[i];
              mode_act[i] <= mode[i];
            end
            en_act <= ctrl_en;
            fsm    <= S_LOAD;
          end
        end
        S_LOAD: begin
          ch    <= '0;
          stg   <= '0;
          x_cur <= samp[0];
          y_cur <= st_mem[0];
          fsm   <= S_MUL;
        end
        S_MUL: fsm <= S_ACC;
        S_ACC: begin
          st_mem[cur_idx] <= y_next;
          // Channel-major state layout: the next stage and the next channel's first stage are both cur_idx+1.
          if (stg == FW'(FILTER_COUNT - 1)) begin
            res[ch] <= stage_out;
            if (ch == CW'(CHANNELS - 1)) begin
              fsm <= S_DONE;
            end else begin
              ch    <= ch + CW'(1);
              stg   <= '0;
              x_cur <= samp[ch + CW'(1)];
              y_cur <= st_mem[cur_idx + IW'(1)];
              fsm   <= S_MUL;
            end
          end else begin
            stg   <= stg + FW'(1);
            x_cur <= stage_out;
            y_cur <= st_mem[cur_idx + IW'(1)];
            fsm   <= S_MUL;
          end
        end
        S_DONE: begin
          for (int i = 0; i < CHANNELS; i++) audio_out[i*B +: B] <= res[i];
          valid_out <= 1'b1;
          fsm       <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  filter_stage_mac #(
    .B      (B),
    .COEF_W (COEF_W),
    .GUARD  (GUARD)
  ) u_mac (
    .clk    (clk_i),
    .rstn   (rst_i),
    .mul_en (fsm == S_MUL),
    .mode   (mac_mode),
    .x      (x_cur),
    .y      (y_cur),
    .k      (COEF_W'(coef_act[stg])),
    .y_next (y_next),
    .out    (stage_out)
  );

endmodule
